fd_stage_reg: RTL and testbench
===============================

FD_STAGE_REG -- requirements
Module: fd_stage_reg

Interface
REQ-001 SHALL have parameter STALL_LIMIT, default 16'd255: consecutive-stall count at which stall_timeout asserts.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on posedge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port fd_en, input, 1: 1 = advance; 0 = hold (hazard stall).
REQ-005 SHALL have port flush, input, 1: squash the instruction entering D on the next advancing edge.
REQ-006 SHALL have port instr_F, input, 32: fetched instruction word.
REQ-007 SHALL have port PC_F, input, 32: fetch PC.
REQ-008 SHALL have port PC8_F, input, 32: fetch PC + 8 (link address).
REQ-009 SHALL have port instr_D, output, 32: registered instruction to decode.
REQ-010 SHALL have port PC_D, output, 32: registered PC.
REQ-011 SHALL have port PC8_D, output, 32: registered PC + 8.
REQ-012 SHALL have port valid_D, output, 1: 1 = instr_D is real; 0 = bubble.
REQ-013 SHALL have port exc_D, output, 5: fetch exception code (0 = none).
REQ-014 SHALL have port stall_cnt, output, 16: consecutive stall cycles, saturating.
REQ-015 SHALL have port stall_timeout, output, 1: registered, high while stall_cnt >= STALL_LIMIT.

Function
REQ-016 SHALL, on a posedge with fd_en=1 and no squash pending, capture instr_F, PC_F, PC8_F into instr_D, PC_D, PC8_D and set valid_D=1: one-cycle latency.
REQ-017 SHALL, on a posedge with fd_en=0, hold instr_D, PC_D, PC8_D, valid_D and exc_D unchanged.
REQ-018 SHALL define squash = flush | flush_pend, where flush_pend is an internal 1-bit register.
REQ-019 SHALL, on a posedge with fd_en=1 and squash=1, load a bubble: instr_D=0, valid_D=0, exc_D=0, PC_D=PC_F, PC8_D=PC8_F; flush_pend cleared.
REQ-020 SHALL, on a posedge with fd_en=0 and flush=1, set flush_pend=1; flush_pend holds until the next fd_en=1 edge.
REQ-021 SHALL apply a squash exactly once, on the first advancing edge, regardless of how many stalled cycles flush was high.
REQ-022 SHALL increment stall_cnt on each posedge with fd_en=0, saturating at 16'hFFFF, and clear it to 0 on any posedge with fd_en=1.
REQ-023 SHALL assert stall_timeout on the edge on which stall_cnt becomes >= STALL_LIMIT and deassert it on the edge on which stall_cnt clears.
REQ-024 SHALL treat STALL_LIMIT=0 as stall_timeout permanently high after reset release.

Reset
REQ-025 SHALL, while reset=1, asynchronously force instr_D=0, PC_D=32'h0000_3000, PC8_D=32'h0000_3008, valid_D=0, exc_D=0, flush_pend=0, stall_cnt=0, stall_timeout=0.
REQ-026 SHALL discard any pending squash when reset asserts mid-stall; the first advancing edge after release captures normally.

Configuration
REQ-027 SHALL, with macro FD_EXC_CHECK_EN defined, flag AdEL (exc_D=5'd4) on a normal capture when PC_F[1:0]!=0 or PC_F is outside 32'h0000_3000..32'h0000_6FFC inclusive, and load instr_D=0 with valid_D=1 in that case.
REQ-028 SHALL, without FD_EXC_CHECK_EN, tie exc_D to 0 and pass instr_F unmodified on every capture.
REQ-029 SHALL give squash (REQ-019) priority over the exception check when both apply.

Verification
REQ-030 Bench SHALL check: reset pulse mid-cycle, no clk edge -> outputs immediately 0 / 0x3000 / 0x3008 / valid 0.
REQ-031 Bench SHALL check: fd_en=1, PC_F=0x3004, instr_F=0x24080001 -> next edge instr_D=0x24080001, PC8_D=0x300C, valid_D=1.
REQ-032 Bench SHALL check: fd_en=0 for 3 cycles with flush high on cycle 2, then fd_en=1 -> D held 3 cycles, then exactly one bubble (valid_D=0), next edge a normal capture.
REQ-033 Bench SHALL check: STALL_LIMIT=4 with fd_en=0 for 6 cycles -> stall_timeout high from 4th edge, stall_cnt=6; fd_en=1 -> both clear next edge.
REQ-034 Bench SHALL check: with FD_EXC_CHECK_EN, PC_F=0x3002 -> exc_D=4, instr_D=0; PC_F=0x7000 -> exc_D=4; same with flush=1 -> exc_D=0, valid_D=0.
REQ-035 Bench SHALL check: without FD_EXC_CHECK_EN, PC_F=0x3002 -> exc_D=0, instr_D=instr_F.

Source files
------------

// File: rtl/fd_stage_reg.sv
// Fetch/decode pipeline register with hazard stall, sticky flush-on-stall and stall watchdog.
// Optional fetch address check enabled by defining FD_EXC_CHECK_EN.
module fd_stage_reg #(
  parameter logic [15:0] STALL_LIMIT = 16'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fd_en,
  input  logic        flush,
  input  logic [31:0] instr_F,
  input  logic [31:0] PC_F,
  input  logic [31:0] PC8_F,
  output logic [31:0] instr_D,
  output logic [31:0] PC_D,
  output logic [31:0] PC8_D,
  output logic        valid_D,
  output logic [4:0]  exc_D,
  output logic [15:0] stall_cnt,
  output logic        stall_timeout
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned EXC_W = 5;
  localparam int unsigned CNT_W = 16;

  localparam logic [XLEN-1:0]  RESET_PC  = 32'h0000_3000;
  localparam logic [XLEN-1:0]  RESET_PC8 = 32'h0000_3008;
  localparam logic [CNT_W-1:0] CNT_MAX   = 16'hFFFF;

`ifdef FD_EXC_CHECK_EN
  localparam logic [EXC_W-1:0] EXC_ADEL  = 5'd4;
  localparam logic [XLEN-1:0]  PC_LO     = 32'h0000_3000;
  localparam logic [XLEN-1:0]  PC_HI     = 32'h0000_6FFC;
`endif

  logic [XLEN-1:0]  instr_nxt;
  logic [XLEN-1:0]  pc_nxt;
  logic [XLEN-1:0]  pc8_nxt;
  logic             valid_nxt;
  logic [EXC_W-1:0] exc_nxt;
  logic             flush_pend;
  logic             flush_pend_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             timeout_nxt;
  logic             squash;
  logic             fetch_fault;

  // Fetch address fault: misaligned or outside the instruction window
`ifdef FD_EXC_CHECK_EN
  always_comb begin
    fetch_fault = (PC_F[1:0] != 2'b00) || (PC_F < PC_LO) || (PC_F > PC_HI);
  end
`else
  always_comb begin
    fetch_fault = 1'b0;
  end
`endif

  // Next-state: advance, squash to bubble, or hold; stall counter and watchdog
  always_comb begin
    instr_nxt      = instr_D;
    pc_nxt         = PC_D;
    pc8_nxt        = PC8_D;
    valid_nxt      = valid_D;
    exc_nxt        = exc_D;
    flush_pend_nxt = flush_pend;
    cnt_nxt        = stall_cnt;
    squash         = flush | flush_pend;

    if (fd_en) begin
      cnt_nxt        = '0;
      flush_pend_nxt = 1'b0;
      pc_nxt         = PC_F;
      pc8_nxt        = PC8_F;
      if (squash) begin
        instr_nxt = '0;
        valid_nxt = 1'b0;
        exc_nxt   = '0;
      end else if (fetch_fault) begin
        instr_nxt = '0;
        valid_nxt = 1'b1;
`ifdef FD_EXC_CHECK_EN
        exc_nxt   = EXC_ADEL;
`else
        exc_nxt   = '0;
`endif
      end else begin
        instr_nxt = instr_F;
        valid_nxt = 1'b1;
        exc_nxt   = '0;
      end
    end else begin
      if (flush) begin
        flush_pend_nxt = 1'b1;
      end
      if (stall_cnt != CNT_MAX) begin
        cnt_nxt = stall_cnt + CNT_W'(1);
      end
    end

    timeout_nxt = (cnt_nxt >= STALL_LIMIT);
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_D       <= '0;
      PC_D          <= RESET_PC;
      PC8_D         <= RESET_PC8;
      valid_D       <= 1'b0;
      exc_D         <= '0;
      flush_pend    <= 1'b0;
      stall_cnt     <= '0;
      stall_timeout <= 1'b0;
    end else begin
      instr_D       <= instr_nxt;
      PC_D          <= pc_nxt;
      PC8_D         <= pc8_nxt;
      valid_D       <= valid_nxt;
      exc_D         <= exc_nxt;
      flush_pend    <= flush_pend_nxt;
      stall_cnt     <= cnt_nxt;
      stall_timeout <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_fd_stage_reg.sv
// Directed bench for fd_stage_reg (STALL_LIMIT=4); exception cases follow FD_EXC_CHECK_EN.
module tb_fd_stage_reg;

  logic        clk;
  logic        reset;
  logic        fd_en;
  logic        flush;
  logic [31:0] instr_F;
  logic [31:0] PC_F;
  logic [31:0] PC8_F;
  logic [31:0] instr_D;
  logic [31:0] PC_D;
  logic [31:0] PC8_D;
  logic        valid_D;
  logic [4:0]  exc_D;
  logic [15:0] stall_cnt;
  logic        stall_timeout;

  int checks = 0;
  int errors = 0;

  fd_stage_reg #(.STALL_LIMIT(16'd4)) dut (
    .clk           (clk),
    .reset         (reset),
    .fd_en         (fd_en),
    .flush         (flush),
    .instr_F       (instr_F),
    .PC_F          (PC_F),
    .PC8_F         (PC8_F),
    .instr_D       (instr_D),
    .PC_D          (PC_D),
    .PC8_D         (PC8_D),
    .valid_D       (valid_D),
    .exc_D         (exc_D),
    .stall_cnt     (stall_cnt),
    .stall_timeout (stall_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic fl, input logic [31:0] ins, input logic [31:0] pc);
    fd_en   = en;
    flush   = fl;
    instr_F = ins;
    PC_F    = pc;
    PC8_F   = pc + 32'd8;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_4000);
    step();
    step();
    checks++;
    if ({instr_D, PC_D, PC8_D} !== {32'h0, 32'h3000, 32'h3008}) begin
      errors++;
      $display("FAIL reset_regs: got %h/%h/%h want 0/3000/3008", instr_D, PC_D, PC8_D);
    end
    checks++;
    if ({valid_D, exc_D, stall_cnt, stall_timeout} !== {1'b0, 5'd0, 16'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_flags: got v=%b exc=%0d cnt=%0d to=%b want 0/0/0/0", valid_D, exc_D, stall_cnt, stall_timeout);
    end
    #2 reset = 1'b0;
  endtask

  task automatic test_capture();
    drive(1'b1, 1'b0, 32'h2408_0001, 32'h0000_3004);
    step();
    checks++;
    if ({instr_D, PC_D, PC8_D, valid_D} !== {32'h2408_0001, 32'h3004, 32'h300C, 1'b1}) begin
      errors++;
      $display("FAIL capture: got %h/%h/%h v=%b want 24080001/3004/300c v=1", instr_D, PC_D, PC8_D, valid_D);
    end
    checks++;
    if (exc_D !== 5'd0) begin
      errors++;
      $display("FAIL capture_exc: got %0d want 0", exc_D);
    end
  endtask

  task automatic test_async_reset();
    // Pulse between edges; outputs must change without any clock edge
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({instr_D, PC_D, PC8_D, valid_D} !== {32'h0, 32'h3000, 32'h3008, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: got %h/%h/%h v=%b want 0/3000/3008 v=0", instr_D, PC_D, PC8_D, valid_D);
    end
    #1 reset = 1'b0;
    // Reset mid-stall drops a pending squash
    drive(1'b0, 1'b1, 32'h1111_0000, 32'h0000_3100);
    step();
    #2 reset = 1'b1;
    #1 reset = 1'b0;
    drive(1'b1, 1'b0, 32'h1111_2222, 32'h0000_3104);
    step();
    checks++;
    if ({instr_D, PC_D, valid_D} !== {32'h1111_2222, 32'h3104, 1'b1}) begin
      errors++;
      $display("FAIL reset_drops_squash: got %h/%h v=%b want 11112222/3104 v=1", instr_D, PC_D, valid_D);
    end
  endtask

  task automatic test_flush_stall();
    drive(1'b1, 1'b0, 32'hAAAA_0001, 32'h0000_3010);
    step();
    for (int i = 1; i <= 3; i++) begin
      drive(1'b0, (i == 2), 32'hBBBB_0000 + 32'(i), 32'h0000_3200 + 32'(4 * i));
      step();
      checks++;
      if ({instr_D, PC_D, PC8_D, valid_D} !== {32'hAAAA_0001, 32'h3010, 32'h3018, 1'b1}) begin
        errors++;
        $display("FAIL stall_hold_%0d: got %h/%h/%h v=%b want aaaa0001/3010/3018 v=1", i, instr_D, PC_D, PC8_D, valid_D);
      end
    end
    checks++;
    if (stall_cnt !== 16'd3) begin
      errors++;
      $display("FAIL stall_cnt3: got %0d want 3", stall_cnt);
    end
    drive(1'b1, 1'b0, 32'hCCCC_0001, 32'h0000_3020);
    step();
    checks++;
    if ({instr_D, PC_D, PC8_D, valid_D, exc_D} !== {32'h0, 32'h3020, 32'h3028, 1'b0, 5'd0}) begin
      errors++;
      $display("FAIL bubble: got %h/%h/%h v=%b exc=%0d want 0/3020/3028 v=0 exc=0", instr_D, PC_D, PC8_D, valid_D, exc_D);
    end
    drive(1'b1, 1'b0, 32'hDDDD_0001, 32'h0000_3030);
    step();
    checks++;
    if ({instr_D, PC_D, valid_D} !== {32'hDDDD_0001, 32'h3030, 1'b1}) begin
      errors++;
      $display("FAIL after_bubble: got %h/%h v=%b want dddd0001/3030 v=1", instr_D, PC_D, valid_D);
    end
    // Flush while advancing squashes immediately
    drive(1'b1, 1'b1, 32'hEEEE_0001, 32'h0000_3040);
    step();
    checks++;
    if ({instr_D, PC_D, valid_D} !== {32'h0, 32'h3040, 1'b0}) begin
      errors++;
      $display("FAIL flush_advance: got %h/%h v=%b want 0/3040 v=0", instr_D, PC_D, valid_D);
    end
  endtask

  task automatic test_timeout();
    drive(1'b0, 1'b0, 32'h0, 32'h0000_3050);
    for (int i = 1; i <= 6; i++) begin
      step();
      checks++;
      if ({stall_cnt, stall_timeout} !== {16'(i), (i >= 4)}) begin
        errors++;
        $display("FAIL timeout_edge_%0d: got cnt=%0d to=%b want cnt=%0d to=%b", i, stall_cnt, stall_timeout, i, (i >= 4));
      end
    end
    drive(1'b1, 1'b0, 32'h1234_5678, 32'h0000_3060);
    step();
    checks++;
    if ({stall_cnt, stall_timeout, valid_D} !== {16'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL timeout_clear: got cnt=%0d to=%b v=%b want 0/0/1", stall_cnt, stall_timeout, valid_D);
    end
  endtask

  task automatic test_exc();
`ifdef FD_EXC_CHECK_EN
    drive(1'b1, 1'b0, 32'h2408_0001, 32'h0000_3002);
    step();
    checks++;
    if ({exc_D, instr_D, valid_D} !== {5'd4, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL exc_misaligned: got exc=%0d ins=%h v=%b want 4/0/1", exc_D, instr_D, valid_D);
    end
    drive(1'b1, 1'b0, 32'h2408_0002, 32'h0000_7000);
    step();
    checks++;
    if ({exc_D, instr_D, valid_D} !== {5'd4, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL exc_range_hi: got exc=%0d ins=%h v=%b want 4/0/1", exc_D, instr_D, valid_D);
    end
    drive(1'b1, 1'b0, 32'h2408_0003, 32'h0000_2FFC);
    step();
    checks++;
    if (exc_D !== 5'd4) begin
      errors++;
      $display("FAIL exc_range_lo: got %0d want 4", exc_D);
    end
    drive(1'b1, 1'b0, 32'h2408_0004, 32'h0000_6FFC);
    step();
    checks++;
    if ({exc_D, instr_D, valid_D} !== {5'd0, 32'h2408_0004, 1'b1}) begin
      errors++;
      $display("FAIL exc_top_ok: got exc=%0d ins=%h v=%b want 0/24080004/1", exc_D, instr_D, valid_D);
    end
    drive(1'b1, 1'b1, 32'h2408_0005, 32'h0000_7000);
    step();
    checks++;
    if ({exc_D, valid_D, instr_D} !== {5'd0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL exc_squash_prio: got exc=%0d v=%b ins=%h want 0/0/0", exc_D, valid_D, instr_D);
    end
`else
    drive(1'b1, 1'b0, 32'h2408_0001, 32'h0000_3002);
    step();
    checks++;
    if ({exc_D, instr_D, valid_D} !== {5'd0, 32'h2408_0001, 1'b1}) begin
      errors++;
      $display("FAIL noexc_misaligned: got exc=%0d ins=%h v=%b want 0/24080001/1", exc_D, instr_D, valid_D);
    end
    drive(1'b1, 1'b0, 32'h2408_0002, 32'h0000_7000);
    step();
    checks++;
    if ({exc_D, instr_D} !== {5'd0, 32'h2408_0002}) begin
      errors++;
      $display("FAIL noexc_range: got exc=%0d ins=%h want 0/24080002", exc_D, instr_D);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_capture();
    test_async_reset();
    test_flush_stall();
    test_timeout();
    test_exc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
